// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into one UART transmitter.
// It launches a byte, waits for the UART to start, waits for it to finish, and flags a start timeout.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | choose a round-robin winner once the UART is quiet
// S_LAUNCH     | one-cycle uart_transmit strobe with the latched byte
// S_WAIT_START | wait for uart_is_transmitting to rise, with a timeout counter
// S_WAIT_DONE  | wait for uart_is_transmitting to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_transmit,
  output logic [7:0]                 uart_tx_byte,
  input  logic                       uart_is_transmitting,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       launch_error
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [7:0] TIMEOUT_CNT = 8'(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_armed;
  logic [GW-1:0]               r_last_grant;
  logic [7:0]                  r_cnt;
  logic [NUM_REQ-1:0][7:0]     w_data_arr;
  logic                        w_found;
  logic [GW-1:0]               w_win_id;
  logic [7:0]                  w_win_data;
  logic                        w_grant;

  assign w_data_arr = req_data;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int k);
    int s;
    s = (int'(last) + 1 + k) % NUM_REQ;
    return GW'(s);
  endfunction

  // Search starts just past the last grant and wraps, so every requester gets a turn.
  always_comb begin
    w_found    = 1'b0;
    w_win_id   = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[rr_idx(r_last_grant, k)]) begin
        w_found    = 1'b1;
        w_win_id   = rr_idx(r_last_grant, k);
        w_win_data = w_data_arr[rr_idx(r_last_grant, k)];
      end
    end
  end

  // r_armed holds off the first grant until one full clock after reset release.
  assign w_grant = (r_state == S_IDLE) && r_armed && !uart_is_transmitting && w_found;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win_id] = 1'b1;
  end

  always_comb begin
    w_next        = r_state;
    uart_transmit = 1'b0;
    launch_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        uart_transmit = 1'b1;
        w_next        = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (uart_is_transmitting) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt >= TIMEOUT_CNT) begin
          launch_error = 1'b1;
          w_next       = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_is_transmitting) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_cnt        <= '0;
      uart_tx_byte <= '0;
      grant_id     <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (w_grant) begin
        uart_tx_byte <= w_win_data;
        grant_id     <= w_win_id;
        r_last_grant <= w_win_id;
      end
      // Saturating so a very long wait can never wrap back under the timeout.
      if (r_state == S_LAUNCH) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_START && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 16, giving the cycles allowed for uart_is_transmitting to rise after a launch (legal range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i offers a byte.
REQ-006 SHALL have port req_data, input, 8*NUM_REQ bits: byte i occupies bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept strobe, asserted for the winning requester only.
REQ-008 SHALL have port uart_transmit, output, 1 bit: start strobe to the UART transmitter.
REQ-009 SHALL have port uart_tx_byte, output, 8 bits: byte presented to the UART transmitter.
REQ-010 SHALL have port uart_is_transmitting, input, 1 bit: busy flag from the UART transmitter.
REQ-011 SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the requester currently being served.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port launch_error, output, 1 bit: one-cycle pulse when a launch times out.

Function
REQ-014 SHALL implement the FSM states IDLE, LAUNCH, WAIT_START and WAIT_DONE.
REQ-015 SHALL, in IDLE with uart_is_transmitting=0 and any req_valid high, choose the winner round-robin:
- search starts at index (last_grant+1) mod NUM_REQ and ascends with wrap.
REQ-016 SHALL, in that same IDLE cycle:
- assert req_ready for the winner only (combinational from req_valid and state);
- register the winner's req_data into uart_tx_byte and its index into grant_id and last_grant;
- go to LAUNCH.
REQ-017 SHALL treat a transfer as complete on the cycle req_valid[i] and req_ready[i] are both high; a requester holds req_data stable while valid and not ready.
REQ-018 SHALL NOT grant in IDLE while uart_is_transmitting=1 (external or leftover activity); req_ready stays 0 until it falls.
REQ-019 SHALL drive uart_transmit=1 for exactly one cycle, in LAUNCH only, then go to WAIT_START with the timeout counter cleared.
REQ-020 SHALL, in WAIT_START, go to WAIT_DONE on the first cycle uart_is_transmitting=1; otherwise increment the counter.
REQ-021 SHALL, when the counter reaches START_TIMEOUT in WAIT_START, pulse launch_error for one cycle and return to IDLE; the byte is dropped and last_grant still advances.
REQ-022 SHALL, in WAIT_DONE, return to IDLE on the first cycle uart_is_transmitting=0.
REQ-023 SHALL hold uart_tx_byte and grant_id stable from LAUNCH through the cycle it leaves WAIT_DONE or WAIT_START.
REQ-024 SHALL keep req_ready all-zero in every state other than IDLE.
REQ-025 SHALL allow a requester whose req_valid drops before it is granted simply to be skipped, with no error.
REQ-026 SHALL make the timeout counter 8 bits wide and saturate it (it never wraps).
REQ-027 SHALL allow a re-grant in the IDLE cycle immediately after WAIT_DONE exits, giving back-to-back bytes with no extra idle cycle beyond IDLE itself.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and all outputs to 0: req_ready, uart_transmit, uart_tx_byte, grant_id, busy and launch_error.
REQ-029 SHALL reset last_grant to NUM_REQ-1 so that requester 0 wins first.
REQ-030 SHALL, on reset asserted mid-operation, drop uart_transmit immediately and abandon the current byte; the UART itself is not reset by this block.
REQ-031 SHALL register the first grant no earlier than the second rising clk edge after rst_n deasserts.

Verification
REQ-032 SHALL cover a single request: req_valid=0001, req_data[7:0]=0x41, UART model raising busy 1 cycle after the strobe for 40 cycles. Required response:
- req_ready=0001 for 1 cycle;
- uart_transmit pulses once with uart_tx_byte=0x41 and grant_id=0;
- busy falls 1 cycle after uart_is_transmitting falls.
REQ-033 SHALL cover round-robin: req_valid=1111 held constant with bytes 0x10,0x11,0x12,0x13. Required response: launch order 0,1,2,3,0 with matching bytes.
REQ-034 SHALL cover fairness after a grant: last grant =2, then req_valid=0101. Required response: requester 0 wins before requester 2.
REQ-035 SHALL cover a launch timeout: UART model never raises uart_is_transmitting. Required response:
- launch_error pulses once, START_TIMEOUT cycles after WAIT_START entry;
- return to IDLE, and the next grant goes to the next index.
REQ-036 SHALL cover an external busy UART: uart_is_transmitting=1 in IDLE with req_valid=0010. Required response:
- no req_ready while busy;
- grant to requester 1 in the first cycle after it falls.
REQ-037 SHALL cover reset during WAIT_DONE: rst_n=0 asynchronously. Required response:
- all outputs 0 before the next clk edge;
- after release, requester 0 has first priority.
